// File: rtl/binary_morph3x3_if.sv
// Pixel-stream bundle for the 3x3 binary morphology filter.
//   iFVAL  frame valid        (source -> filter)
//   iDVAL  pixel valid        (source -> filter)
//   iDATA  12-bit binary pixel (source -> filter)
//   oDVAL  output pixel valid (filter -> sink)
//   oDATA  12-bit output pixel, 0 or 4095 (filter -> sink)
// master: the side that drives the input pixels and observes the result.
// slave:  the filter itself.
interface binary_morph3x3_if;
  logic        iFVAL;
  logic        iDVAL;
  logic [11:0] iDATA;
  logic        oDVAL;
  logic [11:0] oDATA;

  modport master (
    output iFVAL,
    output iDVAL,
    output iDATA,
    input  oDVAL,
    input  oDATA
  );

  modport slave (
    input  iFVAL,
    input  iDVAL,
    input  iDATA,
    output oDVAL,
    output oDATA
  );
endinterface

// File: rtl/binary_morph3x3.sv
// Streaming 3x3 binary erosion (MODE=0) or dilation (MODE=1).
// Ports:
//   iCLK    pixel clock, rising edge
//   iRST    synchronous active-high reset
//   pix_if  slave side of binary_morph3x3_if (iFVAL/iDVAL/iDATA in, oDVAL/oDATA out)
// One output per accepted pixel, one cycle later. The emitted image is the filtered image
// shifted one pixel right and down; out-of-frame window elements read as 0.
module binary_morph3x3 #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter bit          MODE  = 1'b0
) (
  input  logic              iCLK,
  input  logic              iRST,
  binary_morph3x3_if.slave  pix_if
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [2:0]       w0_q, w0_d;   // row y-2, bit0 = column x
  logic [2:0]       w1_q, w1_d;   // row y-1
  logic [2:0]       w2_q, w2_d;   // row y
  logic             dval_q;
  logic [11:0]      data_q, data_d;
  logic [IMG_W-1:0] lb1_q;        // row y-1
  logic [IMG_W-1:0] lb2_q;        // row y-2

  logic       accept;
  logic       pix_b;
  logic       rd1, rd2;
  logic [2:0] col_mask;
  logic [2:0] m0, m1, m2;
  logic       result;

  always_comb begin
    accept = pix_if.iFVAL & pix_if.iDVAL;
    pix_b  = |pix_if.iDATA;
    rd1    = lb1_q[x_q];
    rd2    = lb2_q[x_q];

    x_d  = x_q;
    y_d  = y_q;
    w0_d = w0_q;
    w1_d = w1_q;
    w2_d = w2_q;

    if (!pix_if.iFVAL) begin
      x_d = '0;
      y_d = '0;
    end else if (accept) begin
      w0_d = {w0_q[1:0], rd2};
      w1_d = {w1_q[1:0], rd1};
      w2_d = {w2_q[1:0], pix_b};
      if (x_q == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // Column x-2 is off-frame when x==1; row y-2 is off-frame when y==1. Masked elements
    // read as 0, which forces erosion to 0 and drops them from dilation.
    col_mask = (x_q == XW'(1)) ? 3'b011 : 3'b111;
    m0       = w0_d & col_mask & {3{y_q != YW'(1)}};
    m1       = w1_d & col_mask;
    m2       = w2_d & col_mask;

    if (x_q == '0 || y_q == '0) begin
      result = 1'b0;
    end else if (MODE) begin
      result = |{m0, m1, m2};
    end else begin
      result = &{m0, m1, m2};
    end

    data_d = data_q;
    if (accept) begin
      data_d = result ? 12'hFFF : 12'h000;
    end
  end

  // Line buffers: contents are not reset, stale data is hidden by the border masking.
  // Read-before-write: rd1 carries the old row y-1 bit into row y-2.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb1_q[x_q] <= pix_b;
      lb2_q[x_q] <= rd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_q    <= '0;
      y_q    <= '0;
      w0_q   <= '0;
      w1_q   <= '0;
      w2_q   <= '0;
      dval_q <= 1'b0;
      data_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      w0_q   <= w0_d;
      w1_q   <= w1_d;
      w2_q   <= w2_d;
      dval_q <= accept;
      data_q <= data_d;
    end
  end

  assign pix_if.oDVAL = dval_q;
  assign pix_if.oDATA = data_q;

endmodule

// File: tb/tb_binary_morph3x3.sv
// Self-checking bench: one erosion and one dilation instance driven with the same stream,
// both compared against a frame-array reference model after every clock.
module tb_binary_morph3x3;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_morph3x3_if if_e ();
  binary_morph3x3_if if_d ();

  binary_morph3x3 #(.IMG_W(W), .IMG_H(H), .MODE(1'b0)) u_ero (
    .iCLK   (clk),
    .iRST   (rst),
    .pix_if (if_e)
  );

  binary_morph3x3 #(.IMG_W(W), .IMG_H(H), .MODE(1'b1)) u_dil (
    .iCLK   (clk),
    .iRST   (rst),
    .pix_if (if_d)
  );

  int          vectors = 0;
  int          miscompares = 0;
  bit          img [H][W];
  int          mx, my;
  logic [11:0] last_e, last_d;

  // Window of 3x3 ending at (x,y); off-frame elements are 0; no centre when x or y is 0.
  function automatic bit ref_px(int x, int y, bit dil);
    bit acc;
    bit v;
    if (x == 0 || y == 0) return 1'b0;
    acc = dil ? 1'b0 : 1'b1;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        v = (y - dy < 0 || x - dx < 0) ? 1'b0 : img[y - dy][x - dx];
        acc = dil ? (acc | v) : (acc & v);
      end
    end
    return acc;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s at vector %0d: observed %0d expected %0d", tag, vectors, obs, exp_v);
    end
  endtask

  task automatic step(input bit r, input bit fv, input bit dv, input logic [11:0] d);
    bit exp_dv;
    @(negedge clk);
    rst        = r;
    if_e.iFVAL = fv;
    if_e.iDVAL = dv;
    if_e.iDATA = d;
    if_d.iFVAL = fv;
    if_d.iDVAL = dv;
    if_d.iDATA = d;
    @(posedge clk);
    #1;
    exp_dv = 1'b0;
    if (r) begin
      mx     = 0;
      my     = 0;
      last_e = '0;
      last_d = '0;
    end else if (!fv) begin
      mx = 0;
      my = 0;
    end else if (dv) begin
      exp_dv         = 1'b1;
      img[my][mx]    = (d != 0);
      last_e         = ref_px(mx, my, 1'b0) ? 12'd4095 : 12'd0;
      last_d         = ref_px(mx, my, 1'b1) ? 12'd4095 : 12'd0;
      if (mx == W - 1) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    check("ero_dval", {11'd0, if_e.oDVAL}, {11'd0, exp_dv});
    check("dil_dval", {11'd0, if_d.oDVAL}, {11'd0, exp_dv});
    check("ero_data", if_e.oDATA, last_e);
    check("dil_data", if_d.oDATA, last_d);
    vectors++;
  endtask

  // Idle cycles carry random data that must be ignored.
  task automatic pixel(input logic [11:0] d, input int maxgap);
    int gap;
    gap = $urandom_range(0, maxgap);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b1, 1'b0, 12'($urandom));
    step(1'b0, 1'b1, 1'b1, d);
  endtask

  // kind: 0 all 4095, 1 single 1 at (3,3), 2 sparse random, 3 dense random
  task automatic frame(input int kind, input int maxgap, input int npix);
    logic [11:0] d;
    int n;
    n = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (n < npix) begin
          case (kind)
            0:       d = 12'd4095;
            1:       d = (x == 3 && y == 3) ? 12'd1 : 12'd0;
            2:       d = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(1, 4095)) : 12'd0;
            default: d = ($urandom_range(0, 9) < 8) ? 12'($urandom_range(1, 4095)) : 12'd0;
          endcase
          pixel(d, maxgap);
          n++;
        end
      end
    end
  endtask

  initial begin
    mx = 0;
    my = 0;
    last_e = '0;
    last_d = '0;
    // Reset held with active inputs; outputs must stay 0.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 12'd4095);
    frame(0, 0, W * H);
    frame(1, 0, W * H);
    frame(0, 0, W * H);
    frame(0, 3, W * H);
    // Frame abort via iFVAL, then a clean frame.
    frame(0, 0, 20);
    step(1'b0, 1'b0, 1'b1, 12'd4095);
    step(1'b0, 1'b0, 1'b0, 12'd4095);
    frame(0, 0, W * H);
    // Mid-frame reset, then a clean frame.
    frame(3, 1, 13);
    step(1'b1, 1'b1, 1'b1, 12'd4095);
    frame(0, 0, W * H);
    // Random content, gaps and aborts.
    for (int k = 0; k < 6; k++) begin
      frame(2 + (k % 2), 2, W * H);
      if (k == 2) begin
        frame(3, 0, 30);
        step(1'b0, 1'b0, 1'b0, 12'd0);
      end
    end
    frame(1, 1, W * H);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/binary_morph3x3.md
Name: binary_morph3x3

Overview:
- Streaming 3x3 morphological filter (erosion or dilation) on the binary pixel stream produced by the gray-to-binary threshold stage.
- Sits directly downstream of the thresholder and removes speckle noise before capture/display.
- Uses two internal 1-bit line buffers, producing one output pixel per accepted input pixel.
- Output pixels use the same 12-bit 0/4095 format as the input.

Parameters:
- IMG_W, 640, active pixels per line (>= 3).
- IMG_H, 480, active lines per frame (>= 3).
- MODE, 0, 0 = erosion (AND of window), 1 = dilation (OR of window).

Ports:
- iCLK  input  1  pixel clock; all logic is on the rising edge.
- iRST  input  1  reset, synchronous, active-high.
- iFVAL  input  1  frame valid; low clears the position counters.
- iDVAL  input  1  pixel valid; a pixel is accepted when iDVAL=1 and iFVAL=1.
- iDATA  input  12  binary pixel; any nonzero value = 1, zero = 0.
- oDVAL  output  1  output pixel valid.
- oDATA  output  12  filtered pixel, 4095 or 0.

Behaviour:
- Reset (iRST=1 at a clock edge):
  - oDVAL=0, oDATA=0, x=0, y=0, window shift registers cleared.
  - Line-buffer RAM contents are don't-care; they are masked by the border rule.
  - Reset takes priority over every other input, including mid-frame.
- Position counters:
  - x counts 0..IMG_W-1 on each accepted pixel; at IMG_W-1 it wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1) both wrap to 0.
  - iFVAL=0 at a clock edge forces x=y=0. No pixel is accepted on that cycle.
- Line buffers: two IMG_W x 1-bit buffers, addressed by x.
  - On an accepted pixel, read rows y-1 and y-2 at address x.
  - Write the current bit b into row y-1 and the old row y-1 value into row y-2.
  - Read-before-write at the same address in the same cycle.
- Window:
  - Three 3-bit horizontal shift registers (rows y-2, y-1, y) shift only on accepted pixels.
  - Window = columns x-2..x, rows y-2..y; centre = (cx,cy) = (x-1, y-1).
- Output for an accepted pixel at (x,y):
  - If x==0 or y==0: no centre exists, result = 0.
  - Else any window element with column < 0 or row < 0 is treated as 0. This is the case cx==0 (column x-2) or cy==0 (row y-2).
  - Erosion: result = AND of the 9 elements after masking, so it is 0 whenever cx==0 or cy==0.
  - Dilation: result = OR of the 9 elements after masking.
  - Consequence: the output image is the filtered image shifted one pixel right and down. Image row/column 0 of the output is 0, and filtered centres IMG_W-1 / IMG_H-1 are never emitted.
- Latency and timing:
  - oDVAL <= iDVAL & iFVAL, registered, 1 cycle latency.
  - oDATA <= result ? 4095 : 0, updated only on accepted pixels; it holds its value otherwise.
  - Idle cycles (iDVAL=0) do not advance any state.
  - Output count always equals accepted input count.
- Window compare must be combinational into the output register; no additional pipeline stages.

Test Plan (IMG_W=8, IMG_H=6):
1. Reset: hold iRST=1 for 3 cycles with iDVAL=iFVAL=1 and iDATA=4095 -> oDVAL=0 and oDATA=0 throughout. After release, the first oDVAL=1 appears exactly 1 cycle after the first accepted pixel.
2. MODE=0, full frame of iDATA=4095 -> 48 outputs. oDATA=4095 exactly where x>=2 and y>=2 (24 pixels), otherwise 0.
3. MODE=1, single pixel iDATA=1 at (3,3), all others 0 -> oDATA=4095 exactly at input positions x in 3..5, y in 3..5 (9 pixels), all other 39 outputs 0.
4. MODE=0, same stimulus as test 3 -> all 48 outputs 0. Then a full 4095 frame follows and matches test 2, proving no stale state.
5. Test 2 repeated with random iDVAL=0 gaps of 0-3 cycles between pixels -> identical oDATA sequence and 48 oDVAL pulses, each 1 cycle after its input.
6. iFVAL dropped for 2 cycles after 20 pixels, then a full 4095 frame (MODE=0) -> the new frame's outputs are identical to test 2. Asserting iRST mid-frame likewise restarts at (0,0).
